// File: rtl/mux2_1.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_1
//  Description : Parameterised 2:1 word multiplexer with an optional output
//                register and a saturating counter of select transitions.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_1 #(
    parameter int WIDTH   = 4,
    parameter int OUT_REG = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] sel_toggles
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] w_mux;
    logic             w_sel_changed;
    logic             w_cnt_sat;
    logic             r_sel_q;
    logic [CNT_W-1:0] r_toggles;

    // Word select: only a definite 1 picks in1; anything else (incl. X/Z) falls to in0
    always_comb begin
        w_mux = in0;
        if (sel == 1'b1) begin
            w_mux = in1;
        end
    end

    assign w_sel_changed = (sel != r_sel_q);
    assign w_cnt_sat     = (r_toggles == C_CNT_MAX);

    // Track previous select and count its transitions, holding at the maximum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q   <= 1'b0;
            r_toggles <= '0;
        end else begin
            r_sel_q <= sel;
            if (w_sel_changed && !w_cnt_sat) begin
                r_toggles <= r_toggles + C_CNT_ONE;
            end
        end
    end

    assign sel_toggles = r_toggles;

    generate
        if (OUT_REG != 0) begin : g_reg_out
            logic [WIDTH-1:0] r_out;

            // Registered output: one cycle of latency, cleared by reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out <= '0;
                end else begin
                    r_out <= w_mux;
                end
            end

            assign out = r_out;
        end else begin : g_comb_out
            // Zero-latency steering path; independent of clock and reset
            assign out = w_mux;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mux2_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux2_1
//  Description : Scoreboard bench for mux2_1, combinational and registered
//                builds driven from shared directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_1;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    // Observation points
    localparam int T_OUT_C = 0;
    localparam int T_CNT_C = 1;
    localparam int T_OUT_R = 2;
    localparam int T_CNT_R = 3;

    typedef struct {
        int          tag;
        logic [7:0]  exp;
        string       name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             sel;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_r;
    logic [CNT_W-1:0] cnt_c;
    logic [CNT_W-1:0] cnt_r;

    exp_t exp_q[$];
    event chk_ev;
    int   n_checks;
    int   n_fail;

    mux2_1 #(.WIDTH(WIDTH), .OUT_REG(0), .CNT_W(CNT_W)) dut_c (
        .clk         (clk),
        .rst         (rst),
        .in0         (in0),
        .in1         (in1),
        .sel         (sel),
        .out         (out_c),
        .sel_toggles (cnt_c)
    );

    mux2_1 #(.WIDTH(WIDTH), .OUT_REG(1), .CNT_W(CNT_W)) dut_r (
        .clk         (clk),
        .rst         (rst),
        .in0         (in0),
        .in1         (in1),
        .sel         (sel),
        .out         (out_r),
        .sel_toggles (cnt_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int tag, input logic [7:0] e, input string name);
        exp_t item;
        item.tag  = tag;
        item.exp  = e;
        item.name = name;
        exp_q.push_back(item);
    endtask

    // Hand the queued expectations to the monitor and let it sample
    task automatic flush();
        -> chk_ev;
        #2;
    endtask

    // Monitor: pops every pending expectation and compares against the DUTs
    initial begin
        exp_t       item;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            #1;
            while (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                case (item.tag)
                    T_OUT_C: act = {4'b0, out_c};
                    T_CNT_C: act = cnt_c;
                    T_OUT_R: act = {4'b0, out_r};
                    default: act = cnt_r;
                endcase
                n_checks++;
                if (act !== item.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h at %0t", item.name, act, item.exp, $time);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        sel = 1'b0;
        in0 = 4'b0000;
        in1 = 4'b0000;

        // Reset state, test 1
        @(posedge clk); #1;
        push(T_OUT_C, 8'h00, "reset_out_comb");
        push(T_CNT_C, 8'h00, "reset_cnt_comb");
        push(T_OUT_R, 8'h00, "reset_out_reg");
        push(T_CNT_R, 8'h00, "reset_cnt_reg");
        flush();

        // Test 2: sel=0 picks in0; registered output still cleared by reset
        @(posedge clk); #1;
        rst = 1'b0;
        in0 = 4'b0110;
        in1 = 4'b1001;
        sel = 1'b0;
        push(T_OUT_C, 8'h06, "sel0_out_comb");
        push(T_OUT_R, 8'h00, "sel0_out_reg_in_reset");
        push(T_CNT_C, 8'h00, "sel0_cnt");
        flush();

        // Test 3: sel=1 propagates without any clock edge
        sel = 1'b1;
        push(T_OUT_C, 8'h09, "sel1_no_edge_out_comb");
        push(T_OUT_R, 8'h00, "sel1_no_edge_out_reg_holds");
        flush();

        // Next edge: one transition counted, registered output now 1001
        @(posedge clk); #1;
        push(T_CNT_C, 8'h01, "first_toggle_cnt_comb");
        push(T_CNT_R, 8'h01, "first_toggle_cnt_reg");
        push(T_OUT_R, 8'h09, "reg_latency_out");
        push(T_OUT_C, 8'h09, "sel1_out_comb");
        flush();
        sel = 1'b0;

        // Toggle sel each cycle up to a count of 5
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            push(T_CNT_C, 8'(2 + i), "toggle_cnt");
            push(T_OUT_R, (i % 2 == 0) ? 8'h06 : 8'h09, "toggle_out_reg");
            sel = ~sel;
            push(T_OUT_C, sel ? 8'h09 : 8'h06, "toggle_out_comb");
            flush();
        end

        // Test 5: count is 5; assert reset for one edge with new data
        @(posedge clk); #1;
        push(T_CNT_C, 8'h05, "pre_reset_cnt");
        push(T_OUT_R, 8'h09, "pre_reset_out_reg");
        rst = 1'b1;
        in0 = 4'b0011;
        in1 = 4'b1100;
        push(T_OUT_C, 8'h0c, "reset_asserted_out_comb");
        flush();

        @(posedge clk); #1;
        push(T_CNT_C, 8'h00, "mid_reset_cnt_comb");
        push(T_CNT_R, 8'h00, "mid_reset_cnt_reg");
        push(T_OUT_R, 8'h00, "mid_reset_out_reg");
        push(T_OUT_C, 8'h0c, "mid_reset_out_comb");
        rst = 1'b0;
        flush();

        // sel held at 1 but sel_q was cleared, so this edge counts
        @(posedge clk); #1;
        push(T_CNT_C, 8'h01, "post_reset_cnt");
        push(T_OUT_R, 8'h0c, "post_reset_out_reg");
        flush();

        // Test 4: 300 toggles, count saturates at 255 and holds
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (k == 253 || k == 254 || k == 255 || k == 299) begin
                push(T_CNT_C, (k + 1 > 255) ? 8'hff : 8'(k + 1), "sat_cnt_comb");
                push(T_CNT_R, (k + 1 > 255) ? 8'hff : 8'(k + 1), "sat_cnt_reg");
            end
            sel = ~sel;
            if (k == 253 || k == 254) begin
                push(T_OUT_C, sel ? 8'h0c : 8'h03, "sat_out_comb");
            end
            flush();
        end
        @(posedge clk); #1;
        push(T_CNT_C, 8'hff, "sat_hold_cnt");
        flush();

        // Full-width pass-through vectors
        begin
            logic [3:0] v_in0 [4] = '{4'b1111, 4'b1111, 4'b1010, 4'b0001};
            logic [3:0] v_in1 [4] = '{4'b0000, 4'b0000, 4'b0101, 4'b1000};
            logic       v_sel [4] = '{1'b0,    1'b1,    1'b1,    1'b0};
            logic [7:0] v_exp [4] = '{8'h0f,   8'h00,   8'h05,   8'h01};
            for (int j = 0; j < 4; j++) begin
                @(posedge clk); #1;
                in0 = v_in0[j];
                in1 = v_in1[j];
                sel = v_sel[j];
                push(T_OUT_C, v_exp[j], "width_out_comb");
                flush();
                @(posedge clk); #1;
                push(T_OUT_R, v_exp[j], "width_out_reg");
                flush();
            end
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
